hedios_rx_packetizer: RTL and testbench

Receive-side framing stage of the Hedios serial link. It turns the byte stream from the UART receiver into 5-byte Hedios packets (command byte plus 32-bit little-endian data) and buffers them in a packet FIFO. The FIFO exposes the `rx_empty`/`rx_full`/`rx_lost_data`/`rx_command`/`rx_data`/`rx_pop_packet` interface that the Hedios controller consumes. It also resynchronises the byte stream after a stall using an inter-byte timeout.

---
 rtl/hedios_pkg.sv | 16 +
 rtl/hedios_rx_packetizer_if.sv | 25 ++
 rtl/hedios_packet_fifo.sv | 80 ++++++++
 rtl/hedios_rx_packetizer.sv | 134 +++++++++++++
 tb/tb_hedios_rx_packetizer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/hedios_pkg.sv
// Shared Hedios link types: packet layout and receive-assembler states.
package hedios_pkg;

    localparam int HEDIOS_PACKET_BYTES = 5;

    typedef struct packed {
        logic [7:0]  command;
        logic [31:0] data;
    } hedios_packet_t;

    typedef enum logic {
        WAIT_CMD,
        COLLECT
    } asm_state_t;

endpackage

// File: rtl/hedios_rx_packetizer_if.sv
// Byte-stream input and packet-FIFO controller side of the Hedios receive packetizer.
interface hedios_rx_packetizer_if;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        rx_pop_packet;
    logic        lost_clear;
    logic        rx_empty;
    logic        rx_full;
    logic        rx_lost_data;
    logic [7:0]  rx_command;
    logic [31:0] rx_data;
    logic [7:0]  frame_error_count;

    modport master (
        output byte_valid, byte_data, rx_pop_packet, lost_clear,
        input  rx_empty, rx_full, rx_lost_data, rx_command, rx_data, frame_error_count
    );

    modport slave (
        input  byte_valid, byte_data, rx_pop_packet, lost_clear,
        output rx_empty, rx_full, rx_lost_data, rx_command, rx_data, frame_error_count
    );

endinterface

// File: rtl/hedios_packet_fifo.sv
// Synchronous packet FIFO with registered read; a push into a full FIFO is
// accepted when a pop retires the head entry in the same cycle.
module hedios_packet_fifo
    import hedios_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  hedios_packet_t            push_pkt,
    input  logic                      pop,
    output hedios_packet_t            rd_pkt,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                      empty,
    output logic                      full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    hedios_packet_t mem [FIFO_DEPTH];

    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [CW-1:0]  count_next;
    logic           empty_reg;
    logic           full_reg;
    hedios_packet_t rd_pkt_reg;
    logic           pop_ok;
    logic           push_ok;

    assign pop_ok  = pop && (count_reg != '0);
    assign push_ok = push && ((count_reg < CW'(FIFO_DEPTH)) || pop_ok);

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_pkt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            empty_reg  <= 1'b1;
            full_reg   <= 1'b0;
            rd_pkt_reg <= '0;
        end else begin
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == CW'(FIFO_DEPTH));
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_pkt_reg <= mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

    assign rd_pkt = rd_pkt_reg;
    assign count  = count_reg;
    assign empty  = empty_reg;
    assign full   = full_reg;

endmodule

// File: rtl/hedios_rx_packetizer.sv
// Hedios receive framing: assembles 5-byte packets from the UART byte stream,
// drops stalled partial packets on inter-byte timeout and queues complete ones.
module hedios_rx_packetizer
    import hedios_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hedios_rx_packetizer_if.slave bus
);

    localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_IDX = 3'(HEDIOS_PACKET_BYTES - 1);

    asm_state_t     state_reg, state_next;
    logic [2:0]     idx_reg, idx_next;
    logic [7:0]     cmd_reg, cmd_next;
    logic [23:0]    data_reg, data_next;
    logic [TW-1:0]  tcount_reg, tcount_next;
    logic [7:0]     fec_reg, fec_next;
    logic           lost_reg, lost_next;
    logic           pkt_push;
    logic           drop;
    logic [2:0]     lane_sel;
    hedios_packet_t push_pkt;
    hedios_packet_t rd_pkt;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic           fifo_full;

    // Data bytes 1..3 are staged; byte 4 feeds the packet directly.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            assign lane_sel[gi] = (idx_reg == 3'(gi + 1));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        cmd_next    = cmd_reg;
        data_next   = data_reg;
        tcount_next = tcount_reg;
        fec_next    = fec_reg;
        pkt_push    = 1'b0;
        case (state_reg)
            WAIT_CMD: begin
                if (bus.byte_valid) begin
                    cmd_next    = bus.byte_data;
                    idx_next    = 3'd1;
                    tcount_next = '0;
                    state_next  = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.byte_valid) begin
                    tcount_next = '0;
                    if (idx_reg == LAST_IDX) begin
                        pkt_push   = 1'b1;
                        state_next = WAIT_CMD;
                    end else begin
                        for (int i = 0; i < 3; i++) begin
                            if (lane_sel[i]) begin
                                data_next[8*i +: 8] = bus.byte_data;
                            end
                        end
                        idx_next = idx_reg + 3'd1;
                    end
                end else if (tcount_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle.
                    tcount_next = '0;
                    state_next  = WAIT_CMD;
                    if (fec_reg != 8'hFF) begin
                        fec_next = fec_reg + 8'd1;
                    end
                end else begin
                    tcount_next = tcount_reg + TW'(1);
                end
            end
            default: state_next = WAIT_CMD;
        endcase
    end

    assign push_pkt  = '{command: cmd_reg, data: {bus.byte_data, data_reg}};
    assign drop      = pkt_push && (fifo_count == CW'(FIFO_DEPTH))
                       && !(bus.rx_pop_packet && !fifo_empty);
    assign lost_next = drop ? 1'b1 : (bus.lost_clear ? 1'b0 : lost_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= WAIT_CMD;
            idx_reg    <= '0;
            cmd_reg    <= '0;
            data_reg   <= '0;
            tcount_reg <= '0;
            fec_reg    <= '0;
            lost_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            cmd_reg    <= cmd_next;
            data_reg   <= data_next;
            tcount_reg <= tcount_next;
            fec_reg    <= fec_next;
            lost_reg   <= lost_next;
        end
    end

    hedios_packet_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (pkt_push),
        .push_pkt (push_pkt),
        .pop      (bus.rx_pop_packet),
        .rd_pkt   (rd_pkt),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign bus.rx_empty          = fifo_empty;
    assign bus.rx_full           = fifo_full;
    assign bus.rx_lost_data      = lost_reg;
    assign bus.rx_command        = rd_pkt.command;
    assign bus.rx_data           = rd_pkt.data;
    assign bus.frame_error_count = fec_reg;

endmodule

// File: tb/tb_hedios_rx_packetizer.sv
// Directed bench for the Hedios receive packetizer with a packet-queue scoreboard.
module tb_hedios_rx_packetizer;
    import hedios_pkg::*;

    localparam int DEPTH = 8;
    localparam int TO    = 20;

    logic clk;
    logic rst_n;

    hedios_rx_packetizer_if bus ();

    hedios_rx_packetizer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hedios_packet_t q[$];
    int             errors = 0;
    int             checks = 0;
    int             m_fec  = 0;
    bit             m_lost = 1'b0;
    logic [7:0]     last_cmd  = 8'h00;
    logic [31:0]    last_data = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " empty"}, 32'(bus.rx_empty), 32'(q.size() == 0));
        chk({tag, " full"}, 32'(bus.rx_full), 32'(q.size() == DEPTH));
        chk({tag, " lost"}, 32'(bus.rx_lost_data), 32'(m_lost));
        chk({tag, " command"}, 32'(bus.rx_command), 32'(last_cmd));
        chk({tag, " data"}, bus.rx_data, last_data);
        chk({tag, " fec"}, 32'(bus.frame_error_count), 32'(m_fec));
        $display("txn %-14s empty=%0b full=%0b lost=%0b cmd=%02h data=%08h fec=%0d",
                 tag, bus.rx_empty, bus.rx_full, bus.rx_lost_data,
                 bus.rx_command, bus.rx_data, bus.frame_error_count);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit pop, input bit clr);
        bus.byte_valid    = 1'b1;
        bus.byte_data     = b;
        bus.rx_pop_packet = pop;
        bus.lost_clear    = clr;
        tick();
        bus.byte_valid    = 1'b0;
        bus.rx_pop_packet = 1'b0;
        bus.lost_clear    = 1'b0;
    endtask

    task automatic model_pop();
        hedios_packet_t p;
        if (q.size() > 0) begin
            p         = q.pop_front();
            last_cmd  = p.command;
            last_data = p.data;
        end
    endtask

    task automatic model_push(input logic [7:0] cmd, input logic [31:0] d, input bit clr);
        if (q.size() >= DEPTH) begin
            m_lost = 1'b1;
        end else begin
            q.push_back('{command: cmd, data: d});
            if (clr) m_lost = 1'b0;
        end
    endtask

    // Sends one full packet; pop5/clr5 coincide with the final byte.
    task automatic send_pkt(input logic [7:0] cmd, input logic [31:0] d,
                            input bit pop5, input bit clr5, input string tag);
        logic [7:0] b;
        for (int i = 0; i < HEDIOS_PACKET_BYTES; i++) begin
            if (i == 0) b = cmd;
            else        b = 8'(d >> (8 * (i - 1)));
            drive_byte(b, (i == 4) && pop5, (i == 4) && clr5);
            if (i < 4) idle(3);
        end
        if (pop5) model_pop();
        model_push(cmd, d, clr5);
        check_all(tag);
    endtask

    task automatic pop_pkt(input string tag);
        bus.rx_pop_packet = 1'b1;
        tick();
        bus.rx_pop_packet = 1'b0;
        model_pop();
        check_all(tag);
    endtask

    task automatic clear_lost(input string tag);
        bus.lost_clear = 1'b1;
        tick();
        bus.lost_clear = 1'b0;
        m_lost = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        q.delete();
        m_lost    = 1'b0;
        m_fec     = 0;
        last_cmd  = 8'h00;
        last_data = 32'h0;
        check_all(tag);
    endtask

    initial begin
        bus.byte_valid    = 1'b0;
        bus.byte_data     = 8'h00;
        bus.rx_pop_packet = 1'b0;
        bus.lost_clear    = 1'b0;
        rst_n             = 1'b0;
        tick();
        do_reset("reset");

        // Single packet, then pop, then a pop on an empty FIFO.
        send_pkt(8'h02, 32'h0000_0003, 1'b0, 1'b0, "single");
        pop_pkt("single_pop");
        pop_pkt("empty_pop");

        // Overflow: the ninth packet is dropped.
        for (int i = 1; i <= 9; i++) begin
            send_pkt(8'(i), {4{8'(i)}} ^ 32'h1234_5678, 1'b0, 1'b0, $sformatf("ovf_push%0d", i));
        end
        for (int i = 1; i <= 8; i++) begin
            pop_pkt($sformatf("ovf_pop%0d", i));
        end

        // Lost-flag clear priority and full push-with-pop.
        clear_lost("clr_alone");
        for (int i = 0; i < 8; i++) begin
            send_pkt(8'(8'h20 + i), 32'hA5A5_0000 + 32'(i), 1'b0, 1'b0, $sformatf("fill%0d", i));
        end
        send_pkt(8'h28, 32'hDEAD_BEEF, 1'b0, 1'b1, "drop_and_clr");
        clear_lost("clr_after");
        send_pkt(8'h30, 32'hCAFE_F00D, 1'b1, 1'b0, "full_push_pop");
        for (int i = 0; i < 8; i++) begin
            pop_pkt($sformatf("drain%0d", i));
        end

        // Timeout resync: exactly TO idle cycles discard the partial packet.
        drive_byte(8'hAA, 1'b0, 1'b0);
        idle(3);
        drive_byte(8'hBB, 1'b0, 1'b0);
        idle(TO);
        m_fec++;
        check_all("timeout");
        send_pkt(8'h04, 32'h0, 1'b0, 1'b0, "resync");

        // One idle cycle short of timeout: bytes keep assembling, back to back.
        drive_byte(8'h11, 1'b0, 1'b0);
        drive_byte(8'h22, 1'b0, 1'b0);
        idle(TO - 1);
        drive_byte(8'h33, 1'b0, 1'b0);
        drive_byte(8'h44, 1'b0, 1'b0);
        drive_byte(8'h55, 1'b0, 1'b0);
        model_push(8'h11, 32'h5544_3322, 1'b0);
        check_all("no_timeout");
        pop_pkt("resync_pop");
        pop_pkt("nto_pop");

        // Reset mid-packet with a queued packet and error count present.
        send_pkt(8'h77, 32'h0102_0304, 1'b0, 1'b0, "pre_reset");
        drive_byte(8'h09, 1'b0, 1'b0);
        drive_byte(8'h08, 1'b0, 1'b0);
        drive_byte(8'h07, 1'b0, 1'b0);
        do_reset("mid_reset");
        send_pkt(8'h01, 32'hFFFF_FFFF, 1'b0, 1'b0, "post_reset");
        pop_pkt("post_pop");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
